cacheline_adaptor: RTL and testbench

Memory-side responder for the cache's physical-memory port. It accepts one 256-bit line read or write from the cache (`pmem_*` signals, address plus read/write strobes) and carries it out as a four-beat, 64-bit burst transaction with main memory. The cache holds its request until this block returns a single-cycle `pmem_resp`. The block sits between the cache's `pmem_*` port and the burst memory model or arbiter.

---
 rtl/cacheline_adaptor.sv | 124 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Bridges the cache's single-line pmem port to a four-beat burst memory port.
// Reads assemble beats into pmem_rdata; writes slice the latched line into beats.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pmem_address,
    input  logic                pmem_read,
    input  logic                pmem_write,
    input  logic [s_line-1:0]   pmem_wdata,
    output logic [s_line-1:0]   pmem_rdata,
    output logic                pmem_resp,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    output logic [s_burst-1:0]  burst_o,
    input  logic [s_burst-1:0]  burst_i,
    input  logic                resp_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [1:0]          cnt_r;
    logic [s_line-1:0]   line_r;
    logic [1:0]          next_cnt_s;
    logic [s_burst-1:0]  next_beat_s;

    // Beat that goes on burst_o once the current write beat is accepted
    always_comb begin
        next_cnt_s  = cnt_r + 2'd1;
        next_beat_s = line_r[int'(next_cnt_s) * s_burst +: s_burst];
    end

    // Transaction FSM; every port output is a register updated on the transition into its state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 2'd0;
            line_r     <= '0;
            pmem_rdata <= '0;
            pmem_resp  <= 1'b0;
            address_o  <= 32'd0;
            read_o     <= 1'b0;
            write_o    <= 1'b0;
            burst_o    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pmem_write) begin
                        state_r   <= WRITE;
                        cnt_r     <= 2'd0;
                        line_r    <= pmem_wdata;
                        write_o   <= 1'b1;
                        address_o <= {pmem_address[31:5], 5'd0};
                        burst_o   <= pmem_wdata[s_burst-1:0];
                    end else if (pmem_read) begin
                        state_r   <= READ;
                        cnt_r     <= 2'd0;
                        read_o    <= 1'b1;
                        address_o <= {pmem_address[31:5], 5'd0};
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        pmem_rdata[int'(cnt_r) * s_burst +: s_burst] <= burst_i;
                        if (cnt_r == 2'd3) begin
                            state_r   <= DONE;
                            cnt_r     <= 2'd0;
                            read_o    <= 1'b0;
                            address_o <= 32'd0;
                            pmem_resp <= 1'b1;
                        end else begin
                            cnt_r     <= next_cnt_s;
                        end
                    end else begin
                        state_r <= READ;
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        if (cnt_r == 2'd3) begin
                            state_r   <= DONE;
                            cnt_r     <= 2'd0;
                            write_o   <= 1'b0;
                            address_o <= 32'd0;
                            burst_o   <= '0;
                            pmem_resp <= 1'b1;
                        end else begin
                            cnt_r     <= next_cnt_s;
                            burst_o   <= next_beat_s;
                        end
                    end else begin
                        state_r <= WRITE;
                    end
                end
                DONE: begin
                    // The cache drops its strobe during this cycle, so IDLE never sees a stale request
                    state_r   <= IDLE;
                    pmem_resp <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 2'd0;
                    pmem_resp <= 1'b0;
                    address_o <= 32'd0;
                    read_o    <= 1'b0;
                    write_o   <= 1'b0;
                    burst_o   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a transaction-level model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int total = 0;
    int bad   = 0;
    int resp_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cacheline_adaptor #(.s_line(256), .s_burst(64)) dut (
        .clk(clk), .rst(rst),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
    );

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 reading, 2 writing, 3 completing
    int           m_phase = 0;
    int           m_beats = 0;
    logic [31:0]  m_addr  = 32'd0;
    logic [255:0] m_wline = 256'd0;
    logic [255:0] m_rline = 256'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_beats <= 0;
            m_rline <= 256'd0;
        end else if (m_phase == 0) begin
            if (pmem_write) begin
                m_phase <= 2; m_beats <= 0; m_addr <= pmem_address; m_wline <= pmem_wdata;
            end else if (pmem_read) begin
                m_phase <= 1; m_beats <= 0; m_addr <= pmem_address;
            end
        end else if (m_phase == 3) begin
            m_phase <= 0;
        end else if (resp_i) begin
            if (m_phase == 1) m_rline[m_beats*64 +: 64] <= burst_i;
            m_beats <= m_beats + 1;
            if (m_beats == 3) m_phase <= 3;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [255:0] sh;
        if (chk_en) begin
            sh = m_wline >> (m_beats * 64);
            check("mdl_read_o",  {255'd0, read_o},    {255'd0, m_phase == 1});
            check("mdl_write_o", {255'd0, write_o},   {255'd0, m_phase == 2});
            check("mdl_resp",    {255'd0, pmem_resp}, {255'd0, m_phase == 3});
            check("mdl_addr",    {224'd0, address_o},
                  {224'd0, (m_phase == 1 || m_phase == 2) ? (m_addr & 32'hFFFF_FFE0) : 32'd0});
            check("mdl_burst",   {192'd0, burst_o},   {192'd0, (m_phase == 2) ? sh[63:0] : 64'd0});
            check("mdl_rdata",   pmem_rdata, m_rline);
            if (pmem_resp) resp_cnt++;
        end
    end

    task automatic read_line(input logic [31:0] a, input logic [255:0] ln);
        @(negedge clk); pmem_read = 1'b1; pmem_address = a;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); resp_i = 1'b1; burst_i = ln[k*64 +: 64];
        end
        @(negedge clk); resp_i = 1'b0; burst_i = 64'd0;
        check("rd_resp_at_5", {255'd0, pmem_resp}, {255'd0, 1'b1});
        @(negedge clk); pmem_read = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1; pmem_address = 32'd0; pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_wdata = 256'd0; burst_i = 64'd0; resp_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read_o",  {255'd0, read_o},    256'd0);
        check("rst_write_o", {255'd0, write_o},   256'd0);
        check("rst_resp",    {255'd0, pmem_resp}, 256'd0);
        check("rst_addr",    {224'd0, address_o}, 256'd0);
        check("rst_rdata",   pmem_rdata,          256'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Read at 0x1234 with back-to-back beats, strobe held through pmem_resp
        @(negedge clk); pmem_read = 1'b1; pmem_address = 32'h0000_1234;
        @(negedge clk); resp_i = 1'b1; burst_i = 64'h1111_1111_1111_1111;
        check("t1_read_o", {255'd0, read_o}, {255'd0, 1'b1});
        check("t1_addr", {224'd0, address_o}, {224'd0, 32'h0000_1220});
        @(negedge clk); burst_i = 64'h2222_2222_2222_2222;
        @(negedge clk); burst_i = 64'h3333_3333_3333_3333;
        @(negedge clk); burst_i = 64'h4444_4444_4444_4444;
        check("t1_noresp_c4", {255'd0, pmem_resp}, 256'd0);
        @(negedge clk); resp_i = 1'b0; burst_i = 64'd0;
        check("t1_resp_c5", {255'd0, pmem_resp}, {255'd0, 1'b1});
        check("t1_read_drop", {255'd0, read_o}, 256'd0);
        @(negedge clk); pmem_read = 1'b0;
        check("t1_idle_resp", {255'd0, pmem_resp}, 256'd0);
        @(negedge clk);
        check("t1_no_reread", {255'd0, read_o}, 256'd0);
        check("t1_rdata", pmem_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Write at 0x8000_0040 with a two-cycle gap after beat 1; wdata changed once accepted
        @(negedge clk); pmem_write = 1'b1; pmem_address = 32'h8000_0040;
        pmem_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        @(negedge clk); resp_i = 1'b1;
        pmem_wdata = {256{1'b1}};
        check("t2_beat_a", {192'd0, burst_o}, {192'd0, 64'hAAAA_AAAA_AAAA_AAAA});
        check("t2_addr", {224'd0, address_o}, {224'd0, 32'h8000_0040});
        @(negedge clk);
        check("t2_beat_b", {192'd0, burst_o}, {192'd0, 64'hBBBB_BBBB_BBBB_BBBB});
        for (int g = 0; g < 2; g++) begin
            @(negedge clk); resp_i = 1'b0;
            check("t2_gap_write_o", {255'd0, write_o}, {255'd0, 1'b1});
        end
        @(negedge clk); resp_i = 1'b1;
        check("t2_beat_c", {192'd0, burst_o}, {192'd0, 64'hCCCC_CCCC_CCCC_CCCC});
        @(negedge clk);
        check("t2_beat_d", {192'd0, burst_o}, {192'd0, 64'hDDDD_DDDD_DDDD_DDDD});
        base = resp_cnt;
        @(negedge clk); resp_i = 1'b0;
        check("t2_resp", {255'd0, pmem_resp}, {255'd0, 1'b1});
        @(negedge clk); pmem_write = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_one_resp", 256'(resp_cnt - base), 256'd1);

        // Read and write together: write wins
        base = resp_cnt;
        @(negedge clk); pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_0040;
        pmem_wdata = {64'd4, 64'd3, 64'd2, 64'd1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); resp_i = 1'b1;
            check("t3_read_o_low", {255'd0, read_o}, 256'd0);
            check("t3_beat", {192'd0, burst_o}, {192'd0, 64'(k + 1)});
        end
        @(negedge clk); resp_i = 1'b0;
        @(negedge clk); pmem_read = 1'b0; pmem_write = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_one_resp", 256'(resp_cnt - base), 256'd1);
        check("t3_read_o_after", {255'd0, read_o}, 256'd0);

        // Reset after two read beats, then a fresh read
        base = resp_cnt;
        @(negedge clk); pmem_read = 1'b1; pmem_address = 32'h0000_0100;
        @(negedge clk); resp_i = 1'b1; burst_i = 64'h5555_5555_5555_5555;
        @(negedge clk); burst_i = 64'h6666_6666_6666_6666;
        @(negedge clk); rst = 1'b1; resp_i = 1'b0; pmem_read = 1'b0;
        @(negedge clk); rst = 1'b0;
        check("t5_read_o", {255'd0, read_o}, 256'd0);
        check("t5_addr", {224'd0, address_o}, 256'd0);
        check("t5_rdata", pmem_rdata, 256'd0);
        check("t5_no_resp", 256'(resp_cnt - base), 256'd0);
        read_line(32'h0000_0200, {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                                  64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001});
        check("t5_fresh", pmem_rdata, {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                                       64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001});

        // Spurious resp_i while idle, then a normal read
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_0000_0000 | 64'(k);
        end
        @(negedge clk); resp_i = 1'b0;
        check("t6_idle_read_o", {255'd0, read_o}, 256'd0);
        check("t6_idle_resp", {255'd0, pmem_resp}, 256'd0);
        read_line(32'h0000_0FE7, {64'h0000_0000_0000_00A3, 64'h0000_0000_0000_00A2,
                                  64'h0000_0000_0000_00A1, 64'h0000_0000_0000_00A0});
        check("t6_rdata", pmem_rdata, {64'h0000_0000_0000_00A3, 64'h0000_0000_0000_00A2,
                                       64'h0000_0000_0000_00A1, 64'h0000_0000_0000_00A0});

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
